// File: rtl/adpll_gear_ctrl.sv
// ADPLL acquisition/lock sequencer: gear-shifts loop-filter gains from wide to narrow as phase error settles.
// Optional loss-of-lock statistics counter enabled by defining ADPLL_GEAR_STATS_EN.
module adpll_gear_ctrl #(
    parameter int          ERR_W       = 8,
    parameter int          ACQ_THRESH  = 16,
    parameter int          LOCK_THRESH = 4,
    parameter int          LOCK_CNT    = 16,
    parameter int          LOL_CNT     = 4,
    parameter logic [3:0]  KP_WIDE     = 4'd2,
    parameter logic [3:0]  KI_WIDE     = 4'd4,
    parameter logic [3:0]  KP_NARROW   = 4'd4,
    parameter logic [3:0]  KI_NARROW   = 4'd7
) (
    input  logic             fpga_clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             ref_edge_i,
    input  logic [ERR_W-1:0] error_i,
    input  logic             dco_sat_i,
    output logic [3:0]       kp_shift_o,
    output logic [3:0]       ki_shift_o,
    output logic             int_clr_o,
    output logic [1:0]       state_o,
    output logic             locked_o,
    output logic [7:0]       lol_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        TRACK   = 2'b10,
        LOCKED  = 2'b11
    } state_e;

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int LOL_W = $clog2(LOL_CNT + 1);
    localparam logic [ERR_W-1:0] ACQ_T    = ERR_W'(ACQ_THRESH);
    localparam logic [ERR_W-1:0] LOCK_T   = ERR_W'(LOCK_THRESH);
    localparam logic [RUN_W-1:0] RUN_TGT  = RUN_W'(LOCK_CNT);
    localparam logic [LOL_W-1:0] LOL_TGT  = LOL_W'(LOL_CNT);

    // The most negative code has no positive twin, so it saturates to the largest positive value.
    function automatic logic [ERR_W-1:0] mag_f(input logic [ERR_W-1:0] e);
        logic [ERR_W-1:0] neg_v;
        neg_v = ~e + {{(ERR_W-1){1'b0}}, 1'b1};
        if (!e[ERR_W-1]) begin
            return e;
        end else if (e == {1'b1, {(ERR_W-1){1'b0}}}) begin
            return {1'b0, {(ERR_W-1){1'b1}}};
        end else begin
            return neg_v;
        end
    endfunction

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [LOL_W-1:0] lol_cnt_q, lol_cnt_d;
    logic [3:0]       kp_q, kp_d, ki_q, ki_d;
    logic             int_clr_q, int_clr_d;
    logic             locked_q, locked_d;
    logic             clr_evt_s;
    logic [ERR_W-1:0] mag_s;
    logic             acq_ok_s, lock_ok_s;
    logic [RUN_W-1:0] run_inc_s;
    logic [LOL_W-1:0] lol_inc_s;

    assign mag_s     = mag_f(error_i);
    assign acq_ok_s  = (mag_s <= ACQ_T);
    assign lock_ok_s = (mag_s <= LOCK_T);
    assign run_inc_s = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
    assign lol_inc_s = lol_cnt_q + {{(LOL_W-1){1'b0}}, 1'b1};

`ifdef ADPLL_GEAR_STATS_EN
    logic       lol_evt_s;
    logic [7:0] lol_count_q, lol_count_d;
`endif

    // State and output registers.
    always_ff @(posedge fpga_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            lol_cnt_q <= '0;
            kp_q      <= KP_WIDE;
            ki_q      <= KI_WIDE;
            int_clr_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            lol_cnt_q <= lol_cnt_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            int_clr_q <= int_clr_d;
            locked_q  <= locked_d;
        end
    end

    // Next-state and counter logic; error is only evaluated on reference edges.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        lol_cnt_d = lol_cnt_q;
        clr_evt_s = 1'b0;
`ifdef ADPLL_GEAR_STATS_EN
        lol_evt_s = 1'b0;
`endif
        if (!enable_i) begin
            state_d   = IDLE;
            run_cnt_d = '0;
            lol_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ACQUIRE;
                    clr_evt_s = 1'b1;
                    run_cnt_d = '0;
                    lol_cnt_d = '0;
                end
                ACQUIRE: begin
                    if (!ref_edge_i) begin
                        run_cnt_d = run_cnt_q;
                    end else if (!acq_ok_s) begin
                        run_cnt_d = '0;
                    end else if (run_inc_s == RUN_TGT) begin
                        state_d   = TRACK;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_inc_s;
                    end
                end
                TRACK: begin
                    // A railed DCO outranks every threshold rule.
                    if (!ref_edge_i) begin
                        run_cnt_d = run_cnt_q;
                    end else if (dco_sat_i) begin
                        state_d   = ACQUIRE;
                        clr_evt_s = 1'b1;
                        run_cnt_d = '0;
                    end else if (!acq_ok_s) begin
                        state_d   = ACQUIRE;
                        run_cnt_d = '0;
                    end else if (!lock_ok_s) begin
                        run_cnt_d = '0;
                    end else if (run_inc_s == RUN_TGT) begin
                        state_d   = LOCKED;
                        run_cnt_d = '0;
                        lol_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_inc_s;
                    end
                end
                LOCKED: begin
                    if (!ref_edge_i) begin
                        lol_cnt_d = lol_cnt_q;
                    end else if (dco_sat_i) begin
                        state_d   = ACQUIRE;
                        clr_evt_s = 1'b1;
                        lol_cnt_d = '0;
`ifdef ADPLL_GEAR_STATS_EN
                        lol_evt_s = 1'b1;
`endif
                    end else if (acq_ok_s) begin
                        lol_cnt_d = '0;
                    end else if (lol_inc_s == LOL_TGT) begin
                        state_d   = ACQUIRE;
                        clr_evt_s = 1'b1;
                        lol_cnt_d = '0;
`ifdef ADPLL_GEAR_STATS_EN
                        lol_evt_s = 1'b1;
`endif
                    end else begin
                        lol_cnt_d = lol_inc_s;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    run_cnt_d = '0;
                    lol_cnt_d = '0;
                end
            endcase
        end
    end

    // Output values registered alongside the state they belong to.
    always_comb begin
        kp_d      = KP_WIDE;
        ki_d      = KI_WIDE;
        if ((state_d == TRACK) || (state_d == LOCKED)) begin
            kp_d = KP_NARROW;
            ki_d = KI_NARROW;
        end else begin
            kp_d = KP_WIDE;
            ki_d = KI_WIDE;
        end
        int_clr_d = clr_evt_s;
        locked_d  = (state_d == LOCKED);
    end

`ifdef ADPLL_GEAR_STATS_EN
    // Loss-of-lock event counter; survives disable, cleared only by reset.
    always_comb begin
        lol_count_d = lol_count_q;
        if (lol_evt_s && (lol_count_q != 8'hFF)) begin
            lol_count_d = lol_count_q + 8'd1;
        end else begin
            lol_count_d = lol_count_q;
        end
    end

    // Loss-of-lock statistics register.
    always_ff @(posedge fpga_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lol_count_q <= 8'd0;
        end else begin
            lol_count_q <= lol_count_d;
        end
    end

    assign lol_count_o = lol_count_q;
`else
    assign lol_count_o = 8'd0;
`endif

    assign state_o    = state_q;
    assign kp_shift_o = kp_q;
    assign ki_shift_o = ki_q;
    assign int_clr_o  = int_clr_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_adpll_gear_ctrl.sv
// Directed bench for adpll_gear_ctrl; expected outputs queued per step and compared one cycle later.
module tb_adpll_gear_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00, S_ACQ = 2'b01, S_TRK = 2'b10, S_LCK = 2'b11;
`ifdef ADPLL_GEAR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        logic [1:0] state;
        logic       clr;
        logic [7:0] lol;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       ref_edge;
    logic [7:0] err;
    logic       dco_sat;
    logic [3:0] kp, ki;
    logic       int_clr, locked;
    logic [1:0] state;
    logic [7:0] lol_count;

    int   checks = 0;
    int   errors = 0;
    int   n_lol  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    adpll_gear_ctrl dut (
        .fpga_clk_i (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .ref_edge_i (ref_edge),
        .error_i    (err),
        .dco_sat_i  (dco_sat),
        .kp_shift_o (kp),
        .ki_shift_o (ki),
        .int_clr_o  (int_clr),
        .state_o    (state),
        .locked_o   (locked),
        .lol_count_o(lol_count)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input logic [1:0] st, input logic clr, input logic [7:0] lol);
        logic narrow;
        narrow = (st == S_TRK) || (st == S_LCK);
        chk("state", {6'd0, state}, {6'd0, st});
        chk("kp", {4'd0, kp}, narrow ? 8'd4 : 8'd2);
        chk("ki", {4'd0, ki}, narrow ? 8'd7 : 8'd4);
        chk("int_clr", {7'd0, int_clr}, {7'd0, clr});
        chk("locked", {7'd0, locked}, {7'd0, (st == S_LCK)});
        chk("lol_count", lol_count, lol);
    endtask

    // One clock of stimulus; expectation is queued at drive time and checked after the edge.
    task automatic step(input logic en, input logic re, input logic [7:0] e, input logic sat,
                        input logic [1:0] st, input logic clr);
        exp_t x;
        exp_t y;
        enable   = en;
        ref_edge = re;
        err      = e;
        dco_sat  = sat;
        x.state  = st;
        x.clr    = clr;
        x.lol    = (STATS != 0) ? 8'(n_lol) : 8'd0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        ref_edge = 1'b0;
        dco_sat  = 1'b0;
        y = sb.pop_front();
        chk_outputs(y.state, y.clr, y.lol);
    endtask

    task automatic edges(input int n, input logic [7:0] e, input logic [1:0] mid, input logic [1:0] fin);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, e, 1'b0, (i == n - 1) ? fin : mid, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; ref_edge = 1'b0; err = 8'd0; dco_sat = 1'b0;
        #22;
        chk_outputs(S_IDLE, 1'b0, 8'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'd0, 1'b0, S_IDLE, 1'b0);

        // Enable: integrator clear pulses once on entry to ACQUIRE.
        step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b1);
        step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b0);
        // Out-of-bound sample (17) restarts the run; in ACQUIRE dco_sat has no effect.
        edges(5, 8'd10, S_ACQ, S_ACQ);
        step(1'b1, 1'b1, 8'd17, 1'b0, S_ACQ, 1'b0);
        step(1'b1, 1'b1, 8'd16, 1'b1, S_ACQ, 1'b0);
        edges(14, 8'd10, S_ACQ, S_ACQ);
        step(1'b1, 1'b0, 8'd10, 1'b0, S_ACQ, 1'b0);
        step(1'b1, 1'b1, 8'd10, 1'b0, S_TRK, 1'b0);

        // TRACK: +5 after 15 in-bound resets the run, then -4 boundary qualifies.
        edges(15, 8'hFD, S_TRK, S_TRK);
        step(1'b1, 1'b1, 8'd5, 1'b0, S_TRK, 1'b0);
        edges(16, 8'hFC, S_TRK, S_LCK);

        // LOCKED: interrupted out-of-bound run, then four in a row drop lock.
        edges(3, 8'h80, S_LCK, S_LCK);
        step(1'b1, 1'b1, 8'd0, 1'b0, S_LCK, 1'b0);
        edges(3, 8'd20, S_LCK, S_LCK);
        n_lol = 1;
        step(1'b1, 1'b1, 8'd20, 1'b0, S_ACQ, 1'b1);
        step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b0);

        // Relock, then DCO saturation forces reacquisition.
        edges(16, 8'd0, S_ACQ, S_TRK);
        edges(16, 8'd0, S_TRK, S_LCK);
        n_lol = 2;
        step(1'b1, 1'b1, 8'd0, 1'b1, S_ACQ, 1'b1);
        step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b0);

        // TRACK: large error returns to ACQUIRE without clear; saturation does clear but is not a LOL.
        edges(16, 8'd0, S_ACQ, S_TRK);
        step(1'b1, 1'b1, 8'd17, 1'b0, S_ACQ, 1'b0);
        edges(16, 8'd0, S_ACQ, S_TRK);
        step(1'b1, 1'b1, 8'd0, 1'b1, S_ACQ, 1'b1);

        // Disable: IDLE with statistics retained.
        step(1'b0, 1'b0, 8'd0, 1'b0, S_IDLE, 1'b0);
        step(1'b0, 1'b1, 8'd0, 1'b0, S_IDLE, 1'b0);

        // No reference edges: in-bound error must not advance the run counter.
        step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b0);
        end
        edges(16, 8'd0, S_ACQ, S_TRK);

        // Asynchronous reset mid-run takes effect without a clock edge.
        edges(5, 8'd0, S_TRK, S_TRK);
        #2;
        rst_n = 1'b0;
        #1;
        n_lol = 0;
        chk_outputs(S_IDLE, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'd0, 1'b0, S_ACQ, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
